// File: rtl/median_3x3_stream_pkg.sv
// median_3x3_stream_pkg: shared mode encodings and sizing helper
// for the streaming 3x3 median filter.
package median_3x3_stream_pkg;

  typedef enum logic {
    MODE_MEDIAN = 1'b0,
    MODE_BYPASS = 1'b1
  } mode_e;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/median_3x3_stream_sort.sv
// median9_sort: combinational 19-stage compare-exchange network
// returning the 5th smallest of nine unsigned values.
module median9_sort #(
  parameter int PX_WIDTH = 8
) (
  input  logic [8:0][PX_WIDTH-1:0] i_win,
  output logic [PX_WIDTH-1:0]      o_med
);

  localparam int NCX = 19;
  localparam int CA [NCX] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0,
                              5, 4, 3, 1, 2, 4, 4, 6, 4};
  localparam int CB [NCX] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3,
                              8, 7, 6, 4, 5, 7, 2, 4, 2};

  logic [PX_WIDTH-1:0] w_v [9];
  logic [PX_WIDTH-1:0] w_t;

  // Each stage orders one pair so that w_v[CA] <= w_v[CB].
  always_comb begin
    w_t = '0;
    for (int i = 0; i < 9; i++) w_v[i] = i_win[i];
    for (int k = 0; k < NCX; k++) begin
      if (w_v[CA[k]] > w_v[CB[k]]) begin
        w_t         = w_v[CA[k]];
        w_v[CA[k]]  = w_v[CB[k]];
        w_v[CB[k]]  = w_t;
      end
    end
  end

  assign o_med = w_v[4];

endmodule

// File: rtl/median_3x3_stream.sv
// median_3x3_stream: raster-order 3x3 median / bypass filter
// with two line buffers and a one-deep output register.
module median_3x3_stream
  import median_3x3_stream_pkg::*;
#(
  parameter int PX_WIDTH   = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PX_WIDTH-1:0] in_px_data,
  input  logic                in_px_wr,
  output logic                in_px_full,
  output logic [PX_WIDTH-1:0] out_px_data,
  output logic                out_px_wr,
  input  logic                out_px_full,
  input  logic                mode_sel,
  output logic                frame_done
);

  localparam int CW = clog2(IMG_WIDTH);
  localparam int RW = clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]                 r_col;
  logic [RW-1:0]                 r_row;
  logic [PX_WIDTH-1:0]           r_lb0 [IMG_WIDTH];
  logic [PX_WIDTH-1:0]           r_lb1 [IMG_WIDTH];
  logic [2:0][1:0][PX_WIDTH-1:0] r_win;
  logic [2:0][2:0][PX_WIDTH-1:0] w_nwin;
  logic [8:0][PX_WIDTH-1:0]      w_flat;
  logic [PX_WIDTH-1:0]           w_lb0_rd;
  logic [PX_WIDTH-1:0]           w_lb1_rd;
  logic [PX_WIDTH-1:0]           w_med;
  logic [PX_WIDTH-1:0]           r_out_data;
  logic                          r_out_wr;
  logic                          r_done;
  mode_e                         r_mode;
  logic                          w_acc;
  logic                          w_last_col;
  logic                          w_last_px;
  logic                          w_first_px;
  logic                          w_valid;

  assign in_px_full  = ~(r_out_wr & ~out_px_full);
  assign w_acc       = in_px_wr & in_px_full;
  assign w_last_col  = (r_col == COL_LAST);
  assign w_last_px   = w_last_col & (r_row == ROW_LAST);
  assign w_first_px  = (r_col == '0) & (r_row == '0);
  assign w_valid     = (r_row >= ROW_TWO) & (r_col >= COL_TWO);
  assign w_lb0_rd    = r_lb0[r_col];
  assign w_lb1_rd    = r_lb1[r_col];
  assign out_px_data = r_out_data;
  assign out_px_wr   = r_out_wr;
  assign frame_done  = r_done;

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_px ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Line buffers: lb0 holds the previous line, lb1 the one before.
  always_ff @(posedge clock) begin
    if (w_acc) begin
      r_lb0[r_col] <= in_px_data;
      r_lb1[r_col] <= w_lb0_rd;
    end
  end

  // Window including the incoming column; row 0 is the oldest line.
  always_comb begin
    w_nwin = '0;
    for (int r = 0; r < 3; r++) begin
      w_nwin[r][0] = r_win[r][0];
      w_nwin[r][1] = r_win[r][1];
    end
    w_nwin[0][2] = w_lb1_rd;
    w_nwin[1][2] = w_lb0_rd;
    w_nwin[2][2] = in_px_data;
  end

  assign w_flat = w_nwin;

  // Keep the two newest columns for the next window.
  always_ff @(posedge clock) begin
    if (w_acc) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= w_nwin[r][1];
        r_win[r][1] <= w_nwin[r][2];
      end
    end
  end

  median9_sort #(
    .PX_WIDTH (PX_WIDTH)
  ) u_sort (
    .i_win (w_flat),
    .o_med (w_med)
  );

  // Frame mode is captured with the first pixel only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode <= MODE_MEDIAN;
    end else if (w_acc && w_first_px) begin
      r_mode <= mode_e'(mode_sel);
    end
  end

  // Output register: load on a complete window, clear on transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_wr   <= 1'b0;
      r_out_data <= '0;
    end else if (w_acc && w_valid) begin
      r_out_wr   <= 1'b1;
      r_out_data <= (r_mode == MODE_BYPASS) ? w_nwin[1][1] : w_med;
    end else if (out_px_full) begin
      r_out_wr   <= 1'b0;
    end
  end

  // One-cycle pulse after the last pixel of a frame is taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_acc & w_last_px;
    end
  end

endmodule

// File: doc/median_3x3_stream.md
MEDIAN_3X3_STREAM -- requirements
Module: median_3x3_stream

Interface
REQ-001 SHALL have parameter PX_WIDTH, default 8: pixel bit width, legal range 1..16.
REQ-002 SHALL have parameter IMG_WIDTH, default 64: pixels per line, legal range 3..4096.
REQ-003 SHALL have parameter IMG_HEIGHT, default 64: lines per frame, legal range 3..4096.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_px_data, input, PX_WIDTH bits: input pixel, raster order.
REQ-007 SHALL have port in_px_wr, input, 1 bit: input pixel valid.
REQ-008 SHALL have port in_px_full, output, 1 bit: high means the block accepts a pixel this cycle.
REQ-009 SHALL have port out_px_data, output, PX_WIDTH bits: filtered pixel.
REQ-010 SHALL have port out_px_wr, output, 1 bit: output pixel valid.
REQ-011 SHALL have port out_px_full, input, 1 bit: high means the consumer accepts a pixel this cycle.
REQ-012 SHALL have port mode_sel, input, 1 bit: 0 selects median, 1 selects bypass (window centre pixel).
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-014 SHALL accept an input pixel at a rising edge where in_px_wr=1 and in_px_full=1; pixels with in_px_full=0 SHALL be ignored.
REQ-015 SHALL transfer an output pixel at a rising edge where out_px_wr=1 and out_px_full=1.
REQ-016 SHALL drive in_px_full = NOT(out_px_wr AND NOT out_px_full), so the pipeline stalls only when a held output is blocked.
REQ-017 SHALL hold out_px_data stable while out_px_wr=1 and out_px_full=0.
REQ-018 SHALL track the accepted pixel position with col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1); col wraps to 0 and row increments at end of line; both wrap to 0 after pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-019 SHALL keep two line buffers of IMG_WIDTH x PX_WIDTH plus a 3x3 window register, updated only on accepted pixels.
REQ-020 SHALL form a valid window when the accepted pixel has row>=2 and col>=2; the window is centred on (row-1, col-1).
REQ-021 SHALL emit exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame, in raster order; border pixels SHALL produce no output.
REQ-022 SHALL register the output 1 cycle after the accepted pixel that completes a valid window.
REQ-023 SHALL compute the median as the 5th-smallest of the 9 window values as unsigned PX_WIDTH integers, with ties resolved by value (result independent of position).
REQ-024 SHALL sample mode_sel when the pixel at row=0, col=0 is accepted and apply it to the whole frame; changes mid-frame SHALL have no effect.
REQ-025 SHALL pulse frame_done for 1 cycle, the cycle after the last pixel of a frame is accepted, independent of output backpressure.
REQ-026 SHALL never mix line-buffer contents across frames: windows for row<2 of a new frame SHALL produce no output.

Reset
REQ-027 SHALL, while reset=1 (asynchronous), force col=0, row=0, out_px_wr=0, out_px_data=0, frame_done=0, in_px_full=1, and latched mode=0.
REQ-028 SHALL NOT require clearing of line-buffer or window contents on reset; a reset mid-frame SHALL restart at pixel (0,0) and discard any pending output.

Structure
REQ-029 SHALL place in the shared package: the mode encodings (MODE_MEDIAN=0, MODE_BYPASS=1) and a clog2 helper for counter widths.
REQ-030 SHALL implement the 9-input median as the sub-module median9_sort: a combinational compare-exchange network, PX_WIDTH-parametrised.
REQ-031 SHALL infer the line buffers as simple dual-port memory: one read and one write per accepted pixel.

Verification
REQ-032 SHALL check: 4x4 frame, all pixels 8'h55, out_px_full=1 -> 4 outputs, each 8'h55, frame_done pulses once.
REQ-033 SHALL check: 5x5 frame of 8'h10 with single 8'hFF at (2,2) -> 9 outputs, all 8'h10.
REQ-034 SHALL check: 4x4 ramp p=4*row+col, mode_sel=1 -> outputs 5, 6, 9, 10.
REQ-035 SHALL check: out_px_full=0 for 5 cycles while out_px_wr=1 -> in_px_full=0, out_px_data unchanged; no pixel is lost.
REQ-036 SHALL check: reset asserted after 7 pixels of a 4x4 frame, then a full 16-pixel frame is fed -> exactly 4 outputs matching a fresh frame.
REQ-037 SHALL check: mode_sel toggled mid-frame -> the frame keeps the mode latched at (0,0); the next frame uses the new mode.
